// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state type and decode helpers for the multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [5:0] OP_MUL    = 6'b100111;
  localparam logic [5:0] OP_MULH   = 6'b101000;
  localparam logic [5:0] OP_MULHU  = 6'b101001;
  localparam logic [5:0] OP_MULHSU = 6'b101010;
  localparam logic [5:0] OP_DIV    = 6'b101011;
  localparam logic [5:0] OP_DIVU   = 6'b101100;
  localparam logic [5:0] OP_REM    = 6'b101101;
  localparam logic [5:0] OP_REMU   = 6'b101110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] op);
    logic r_hit;
    case (op)
      OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: r_hit = 1'b1;
      default:                          r_hit = 1'b0;
    endcase
    return r_hit;
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    logic r_hit;
    case (op)
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: r_hit = 1'b1;
      default:                          r_hit = 1'b0;
    endcase
    return r_hit;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, subtract-restore for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_operand,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_operand} : {(XLEN+1){1'b0}});
  assign w_shift = {i_hi, i_lo[XLEN-1]};
  // Partial remainder stays below the divisor, so bit XLEN of the difference is the borrow.
  assign w_diff  = w_shift - {1'b0, i_operand};

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_is_div) begin
      if (!w_diff[XLEN]) begin
        o_hi = w_diff[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_hi = w_shift[XLEN-1:0];
        o_lo = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[XLEN:1];
      o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer with pipeline stall handshake.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; divides always iterate.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [5:0]      i_alu_control,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_t          r_state, w_next_state;
  logic [CW-1:0]   r_count;
  logic [5:0]      r_op;
  logic            r_is_div, r_neg_q, r_neg_r, r_done;
  logic [XLEN-1:0] r_hi, r_lo, r_operand, r_result;

  logic            w_accept, w_is_div, w_signed_a, w_signed_b, w_a_neg, w_b_neg;
  logic            w_div_zero, w_overflow, w_bypass, w_is_rem_in, w_last;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_hi, w_lo;
  logic [XLEN-1:0] w_calc_result, w_bypass_result, w_fast_result, w_quot, w_rem;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept    = (r_state == ST_IDLE) & i_start & is_muldiv(i_alu_control);
  assign w_is_div    = is_div_op(i_alu_control);
  assign w_is_rem_in = (i_alu_control == OP_REM) | (i_alu_control == OP_REMU);
  assign w_a_neg     = w_signed_a & i_a[XLEN-1];
  assign w_b_neg     = w_signed_b & i_b[XLEN-1];
  assign w_mag_a     = w_a_neg ? -i_a : i_a;
  assign w_mag_b     = w_b_neg ? -i_b : i_b;
  assign w_div_zero  = w_is_div & (i_b == {XLEN{1'b0}});
  assign w_overflow  = ((i_alu_control == OP_DIV) | (i_alu_control == OP_REM)) &
                       (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == {XLEN{1'b1}});
  assign w_last      = (r_count == CW'(XLEN-1));

  always_comb begin
    w_signed_a = 1'b0;
    w_signed_b = 1'b0;
    case (i_alu_control)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        w_signed_a = 1'b1;
        w_signed_b = 1'b1;
      end
      OP_MULHSU: w_signed_a = 1'b1;
      default: begin
        w_signed_a = 1'b0;
        w_signed_b = 1'b0;
      end
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_raw, w_fast_prod;
  assign w_fast_raw    = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
  assign w_fast_prod   = (w_a_neg ^ w_b_neg) ? -w_fast_raw : w_fast_raw;
  assign w_fast_result = (i_alu_control == OP_MUL) ? w_fast_prod[XLEN-1:0]
                                                   : w_fast_prod[2*XLEN-1:XLEN];
  assign w_bypass      = w_div_zero | w_overflow | ~w_is_div;
`else
  assign w_fast_result = {XLEN{1'b0}};
  assign w_bypass      = w_div_zero | w_overflow;
`endif

  always_comb begin
    if (w_div_zero) begin
      w_bypass_result = w_is_rem_in ? i_a : {XLEN{1'b1}};
    end else if (w_overflow) begin
      w_bypass_result = w_is_rem_in ? {XLEN{1'b0}} : i_a;
    end else begin
      w_bypass_result = w_fast_result;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_is_div (r_is_div),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_operand(r_operand),
    .o_hi     (w_hi),
    .o_lo     (w_lo)
  );

  // Sign fix-up applied to the final iteration's outputs as FIN is entered.
  assign w_prod = r_neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
  assign w_quot = r_neg_q ? -w_lo : w_lo;
  assign w_rem  = r_neg_r ? -w_hi : w_hi;

  always_comb begin
    case (r_op)
      OP_MUL:                      w_calc_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHU, OP_MULHSU: w_calc_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             w_calc_result = w_quot;
      OP_REM, OP_REMU:             w_calc_result = w_rem;
      default:                     w_calc_result = {XLEN{1'b0}};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_flush) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            w_next_state = w_bypass ? ST_FIN : ST_CALC;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_CALC: w_next_state = w_last ? ST_FIN : ST_CALC;
        ST_FIN:  w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_stall = w_accept | (r_state == ST_CALC);
    o_busy  = (r_state != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count   <= {CW{1'b0}};
      r_op      <= 6'd0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_hi      <= {XLEN{1'b0}};
      r_lo      <= {XLEN{1'b0}};
      r_operand <= {XLEN{1'b0}};
    end else if (i_flush) begin
      r_count <= {CW{1'b0}};
    end else if (w_accept) begin
      r_count   <= {CW{1'b0}};
      r_op      <= i_alu_control;
      r_is_div  <= w_is_div;
      r_neg_q   <= w_a_neg ^ w_b_neg;
      r_neg_r   <= w_a_neg;
      r_hi      <= {XLEN{1'b0}};
      r_lo      <= w_is_div ? w_mag_a : w_mag_b;
      r_operand <= w_is_div ? w_mag_b : w_mag_a;
    end else if (r_state == ST_CALC) begin
      r_count <= w_last ? {CW{1'b0}} : r_count + CW'(1);
      r_hi    <= w_hi;
      r_lo    <= w_lo;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done   <= 1'b0;
      r_result <= {XLEN{1'b0}};
    end else begin
      r_done <= (w_next_state == ST_FIN);
      if (w_next_state == ST_FIN) begin
        r_result <= (r_state == ST_IDLE) ? w_bypass_result : w_calc_result;
      end
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (XLEN = 32).
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT    = 1;
  localparam int MUL_STALLS = 1;
`else
  localparam int MUL_LAT    = 33;
  localparam int MUL_STALLS = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  alu = 6'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        flush = 1'b0;
  logic        stall, done, busy;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_alu_control(alu),
    .i_a(opa), .i_b(opb), .i_flush(flush),
    .o_stall(stall), .o_done(done), .o_result(result), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; cycle 0 is the start cycle, returns at the done cycle.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int stalls, output logic [31:0] res);
    start = 1'b1; alu = op; opa = a; opb = b;
    lat = -1; stalls = 0; res = 32'd0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (stall) stalls++;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  int          lat, stalls, done_cnt;
  logic [31:0] res;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("reset_result", {32'd0, result}, 64'd0);
    check_eq("reset_done",   {63'd0, done},   64'd0);
    check_eq("reset_busy",   {63'd0, busy},   64'd0);
    check_eq("reset_stall",  {63'd0, stall},  64'd0);
    @(negedge clk);
    rst = 1'b0;

    @(negedge clk);
    do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, stalls, res);
    check_eq("mul_result", {32'd0, res}, 64'hFFFF_FFEB);
    check_eq("mul_lat",    64'(lat),    64'(MUL_LAT));
    check_eq("mul_stalls", 64'(stalls), 64'(MUL_STALLS));
    @(negedge clk); #1;
    check_eq("mul_done_pulse", {63'd0, done}, 64'd0);
    check_eq("mul_idle_busy",  {63'd0, busy}, 64'd0);

    @(negedge clk);
    do_op(OP_DIVU, 32'd100, 32'd7, lat, stalls, res);
    check_eq("divu_result", {32'd0, res}, 64'd14);
    check_eq("divu_lat",    64'(lat), 64'd33);
    start = 1'b1; alu = OP_REMU;
    #1;
    check_eq("fin_stall_low", {63'd0, stall}, 64'd0);
    @(negedge clk);
    do_op(OP_REMU, 32'd100, 32'd7, lat, stalls, res);
    check_eq("remu_result", {32'd0, res}, 64'd2);
    check_eq("remu_lat",    64'(lat), 64'd33);

    @(negedge clk);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls, res);
    check_eq("div_ovf_result", {32'd0, res}, 64'h8000_0000);
    check_eq("div_ovf_lat",    64'(lat), 64'd1);
    @(negedge clk);
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, stalls, res);
    check_eq("rem_ovf_result", {32'd0, res}, 64'd0);
    @(negedge clk);
    do_op(OP_DIV, 32'd5, 32'd0, lat, stalls, res);
    check_eq("div_zero_result", {32'd0, res}, 64'hFFFF_FFFF);
    check_eq("div_zero_lat",    64'(lat), 64'd1);
    @(negedge clk);
    do_op(OP_REM, 32'd5, 32'd0, lat, stalls, res);
    check_eq("rem_zero_result", {32'd0, res}, 64'd5);

    @(negedge clk);
    do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, res);
    check_eq("mulhu_result", {32'd0, res}, 64'hFFFF_FFFE);
    check_eq("mulhu_lat",    64'(lat), 64'(MUL_LAT));
    @(negedge clk);
    do_op(OP_MULH, 32'hFFFF_FFF9, 32'd3, lat, stalls, res);
    check_eq("mulh_result", {32'd0, res}, 64'hFFFF_FFFF);
    @(negedge clk);
    do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, stalls, res);
    check_eq("mulhsu_result", {32'd0, res}, 64'hFFFF_FFFF);
    @(negedge clk);
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, lat, stalls, res);
    check_eq("div_neg_result", {32'd0, res}, 64'hFFFF_FFF2);
    @(negedge clk);
    do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, lat, stalls, res);
    check_eq("rem_neg_result", {32'd0, res}, 64'hFFFF_FFFE);

    // Flush at cycle 10 of a DIV; last result was 0xFFFFFFFE.
    @(negedge clk);
    start = 1'b1; alu = OP_DIV; opa = 32'd1000; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    check_eq("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush_busy_after", {63'd0, busy}, 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_cnt++;
      @(negedge clk); #1;
    end
    check_eq("flush_no_done", 64'(done_cnt), 64'd0);
    check_eq("flush_result",  {32'd0, result}, 64'hFFFF_FFFE);

    // Same sequence with reset at cycle 10.
    @(negedge clk);
    start = 1'b1; alu = OP_DIV; opa = 32'd1000; opb = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_busy_after", {63'd0, busy},   64'd0);
    check_eq("rst_result",     {32'd0, result}, 64'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_cnt++;
      @(negedge clk); #1;
    end
    check_eq("rst_no_done", 64'(done_cnt), 64'd0);

    // Flush wins over a simultaneous start in IDLE.
    @(negedge clk);
    start = 1'b1; alu = OP_DIVU; opa = 32'd9; opb = 32'd2; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check_eq("flush_start_busy", {63'd0, busy}, 64'd0);

    // Unrecognised code (ADD) is ignored.
    @(negedge clk);
    start = 1'b1; alu = 6'b000000; opa = 32'd1; opb = 32'd2;
    #1;
    check_eq("add_stall", {63'd0, stall}, 64'd0);
    done_cnt = 0;
    @(negedge clk);
    #1;
    check_eq("add_busy", {63'd0, busy}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      if (done) done_cnt++;
      @(negedge clk); #1;
    end
    start = 1'b0;
    check_eq("add_no_done", 64'(done_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand/result width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 start  input  1  SHALL request an operation; held high by the pipeline while stalled.
REQ-005 aluControl  input  6  SHALL be the operation code produced by control_unit.
REQ-006 a, b  input  XLEN  SHALL be rs1/rs2 operands, sampled only at acceptance.
REQ-007 flush  input  1  SHALL abort any operation in progress.
REQ-008 stall  output  1  SHALL hold the pipeline while an operation is pending.
REQ-009 done  output  1  SHALL pulse for one cycle when result is valid.
REQ-010 result  output  XLEN  SHALL be the registered operation result.
REQ-011 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-012 Recognised codes: MUL 100111, MULH 101000, MULHU 101001, MULHSU 101010, DIV 101011, DIVU 101100, REM 101101, REMU 101110; any other code SHALL be ignored (no acceptance, stall low).
REQ-013 FSM states: IDLE, CALC, FIN; IDLE->CALC on accept, CALC->FIN when step counter reaches XLEN-1, FIN->IDLE unconditionally.
REQ-014 Accept SHALL occur when state=IDLE and start=1 with a recognised code; operands, code and sign flags latched that edge.
REQ-015 stall SHALL equal (IDLE & start & recognised) | (state=CALC); stall SHALL be low in FIN.
REQ-016 Iterative ops: CALC SHALL last exactly XLEN cycles (one radix-2 step per cycle); done SHALL be high in the cycle XLEN+1 after the start cycle.
REQ-017 Multiply: shift-add on operand magnitudes, 2*XLEN product, negated when signs differ; MUL returns low half, MULH/MULHU/MULHSU high half with signed/unsigned/signed-unsigned operand interpretation.
REQ-018 Divide: restoring on magnitudes; quotient negated when signs differ, remainder takes dividend sign (DIV/REM only).
REQ-019 Divide by zero SHALL bypass CALC (IDLE->FIN): quotient all-ones, remainder = a; done in cycle 1 after start.
REQ-020 Signed overflow (a = most-negative, b = -1, DIV/REM) SHALL bypass CALC: quotient = a, remainder = 0; done in cycle 1.
REQ-021 result SHALL be updated only on FIN entry and held until the next FIN entry.
REQ-022 start in FIN SHALL be ignored; a back-to-back request is accepted in the following IDLE cycle.
REQ-023 flush SHALL force IDLE next edge from any state, suppress done, leave result unchanged; flush wins over simultaneous start.

Reset
REQ-024 rst SHALL force state IDLE, counter 0, result 0, done 0, busy 0; stall then depends only on start/aluControl.
REQ-025 rst mid-CALC SHALL discard the operation with no done pulse; rst has priority over flush and start.

Configuration
REQ-026 Macro MULDIV_FAST_MUL_EN defined: multiply ops SHALL bypass CALC using a single-cycle XLEN x XLEN product, done in cycle 1 after start.
REQ-027 MULDIV_FAST_MUL_EN undefined: multiply ops SHALL use the XLEN-cycle iterative path of REQ-016; divide timing identical in both builds.

Structure
REQ-028 Package muldiv_pkg SHALL hold the eight opcode constants, the FSM state typedef and an is_muldiv helper function.
REQ-029 Sub-module muldiv_step SHALL hold the combinational one-iteration datapath (add-shift / subtract-restore); FSM, counter and sign fix-up stay in muldiv_sequencer.

Verification
REQ-030 MUL a=7, b=-3, start 1 cycle -> stall high 33 cycles, done at cycle 33, result=0xFFFFFFEB.
REQ-031 DIVU a=100, b=7 then REMU same operands back-to-back -> results 14 then 2, each done 33 cycles after its acceptance.
REQ-032 DIV a=0x80000000, b=0xFFFFFFFF -> done cycle 1, result 0x80000000; DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5.
REQ-033 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; with MULDIV_FAST_MUL_EN, done at cycle 1.
REQ-034 DIV started, flush at cycle 10 -> IDLE at cycle 11, no done, result unchanged; repeat with rst -> result 0.
REQ-035 start with aluControl=000000 (ADD) -> stall low, busy low, no done.
